// File: rtl/complex_iq_combiner_axis_if.sv
// AXI4-Stream beat bundle used for both partial-product inputs and the combined output.
// TDATA packs two signed components as {hi, lo}.
interface complex_iq_combiner_axis_if #(
    parameter int DATA_W = 32
) ();
    logic [2*DATA_W-1:0] TDATA;
    logic                TVALID;
    logic                TLAST;
    logic                TREADY;

    modport master (output TDATA, TVALID, TLAST, input TREADY);
    modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/complex_iq_combiner_axis.sv
// Joins two {hi,lo} partial-product streams into one complex stream through a stall-as-a-whole
// pipeline, with runtime combine mode, saturate/wrap, and sticky overflow / TLAST-mismatch status.
module complex_iq_combiner_axis #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2,
    parameter int SATURATE    = 1
) (
    input  logic                      AXIS_ACLK,
    input  logic                      AXIS_ARESET,
    input  logic [1:0]                MODE,
    input  logic                      STATUS_CLR,
    complex_iq_combiner_axis_if.slave  S0_AXIS,
    complex_iq_combiner_axis_if.slave  S1_AXIS,
    complex_iq_combiner_axis_if.master M_AXIS,
    output logic [DATA_W/4-1:0]       M_AXIS_TSTRB,
    output logic                      OVF_STICKY,
    output logic                      LAST_MISMATCH,
    output logic [31:0]               BEAT_CNT
);
    localparam int W  = DATA_W;
    localparam int TW = 2 * DATA_W;

    logic          ce;
    logic          accept;
    logic [W:0]    a_hi, a_lo, b_hi, b_lo;
    logic [W:0]    r_hi, r_lo;
    logic [W:0]    f_hi, f_lo;
    logic [TW-1:0] res_d;
    logic          res_ovf_d;

    logic          valid_q [PIPE_STAGES];
    logic [TW-1:0] data_q  [PIPE_STAGES];
    logic          last_q  [PIPE_STAGES];
    logic          ovf_q   [PIPE_STAGES];

    logic          ovf_sticky_q, ovf_sticky_d;
    logic          mismatch_q, mismatch_d;
    logic [31:0]   beat_cnt_q, beat_cnt_d;

    // Returns {overflow, fitted value}; the W+1-bit result overflowed when its top two bits differ.
    function automatic logic [W:0] fit(input logic [W:0] r);
        logic         ovf;
        logic [W-1:0] v;
        ovf = r[W] ^ r[W-1];
        v   = r[W-1:0];
        if (ovf && (SATURATE != 0)) begin
            v = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return {ovf, v};
    endfunction

    assign ce     = !valid_q[PIPE_STAGES-1] || M_AXIS.TREADY;
    assign accept = !AXIS_ARESET && ce && S0_AXIS.TVALID && S1_AXIS.TVALID;

    assign S0_AXIS.TREADY = !AXIS_ARESET && ce && S1_AXIS.TVALID;
    assign S1_AXIS.TREADY = !AXIS_ARESET && ce && S0_AXIS.TVALID;

    always_comb begin
        a_hi = {S0_AXIS.TDATA[TW-1], S0_AXIS.TDATA[TW-1:W]};
        a_lo = {S0_AXIS.TDATA[W-1],  S0_AXIS.TDATA[W-1:0]};
        b_hi = {S1_AXIS.TDATA[TW-1], S1_AXIS.TDATA[TW-1:W]};
        b_lo = {S1_AXIS.TDATA[W-1],  S1_AXIS.TDATA[W-1:0]};
        r_hi = a_hi + b_hi;
        r_lo = a_lo + b_lo;
        case (MODE)
            2'd0: begin
                r_hi = a_hi + b_lo;
                r_lo = a_lo - b_hi;
            end
            2'd2: begin
                r_hi = a_hi - b_hi;
                r_lo = a_lo - b_lo;
            end
            2'd3: begin
                r_hi = a_hi - b_lo;
                r_lo = a_lo + b_hi;
            end
            default: ;
        endcase
        f_hi      = fit(r_hi);
        f_lo      = fit(r_lo);
        res_d     = {f_hi[W-1:0], f_lo[W-1:0]};
        res_ovf_d = f_hi[W] | f_lo[W];
    end

    always_comb begin
        ovf_sticky_d = (ovf_sticky_q && !STATUS_CLR)
                     || (valid_q[PIPE_STAGES-1] && M_AXIS.TREADY && ovf_q[PIPE_STAGES-1]);
        mismatch_d   = (mismatch_q && !STATUS_CLR)
                     || (accept && (S0_AXIS.TLAST != S1_AXIS.TLAST));
        beat_cnt_d   = beat_cnt_q + {31'b0, accept};
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                last_q[i]  <= 1'b0;
                ovf_q[i]   <= 1'b0;
            end
            ovf_sticky_q <= 1'b0;
            mismatch_q   <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            if (ce) begin
                valid_q[0] <= accept;
                if (accept) begin
                    data_q[0] <= res_d;
                    last_q[0] <= S0_AXIS.TLAST | S1_AXIS.TLAST;
                    ovf_q[0]  <= res_ovf_d;
                end
                for (int i = 1; i < PIPE_STAGES; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= data_q[i-1];
                    last_q[i]  <= last_q[i-1];
                    ovf_q[i]   <= ovf_q[i-1];
                end
            end
            ovf_sticky_q <= ovf_sticky_d;
            mismatch_q   <= mismatch_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign M_AXIS.TDATA  = data_q[PIPE_STAGES-1];
    assign M_AXIS.TVALID = valid_q[PIPE_STAGES-1];
    assign M_AXIS.TLAST  = last_q[PIPE_STAGES-1];
    assign M_AXIS_TSTRB  = '1;
    assign OVF_STICKY    = ovf_sticky_q;
    assign LAST_MISMATCH = mismatch_q;
    assign BEAT_CNT      = beat_cnt_q;
endmodule

// File: tb/tb_complex_iq_combiner_axis.sv
// Bench for complex_iq_combiner_axis: directed cases plus randomized streams scored against a
// plain-arithmetic model. A second instance (wrap mode, deeper pipe) shares the stimulus.
module tb_complex_iq_combiner_axis;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        status_clr;
    logic        m_ready;
    logic [7:0]  tstrb, tstrb_w;
    logic        ovf, mm, ovf_w, mm_w;
    logic [31:0] cnt, cnt_w;
    int          errors, checks, beat_exp;

    always #5 clk = ~clk;

    complex_iq_combiner_axis_if #(.DATA_W(32)) s0_if ();
    complex_iq_combiner_axis_if #(.DATA_W(32)) s1_if ();
    complex_iq_combiner_axis_if #(.DATA_W(32)) m_if ();
    complex_iq_combiner_axis_if #(.DATA_W(32)) s0w ();
    complex_iq_combiner_axis_if #(.DATA_W(32)) s1w ();
    complex_iq_combiner_axis_if #(.DATA_W(32)) mw ();

    assign s0w.TDATA  = s0_if.TDATA;
    assign s0w.TVALID = s0_if.TVALID;
    assign s0w.TLAST  = s0_if.TLAST;
    assign s1w.TDATA  = s1_if.TDATA;
    assign s1w.TVALID = s1_if.TVALID;
    assign s1w.TLAST  = s1_if.TLAST;
    assign m_if.TREADY = m_ready;
    assign mw.TREADY   = m_ready;

    complex_iq_combiner_axis #(.DATA_W(32), .PIPE_STAGES(2), .SATURATE(1)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst), .MODE(mode), .STATUS_CLR(status_clr),
        .S0_AXIS(s0_if), .S1_AXIS(s1_if), .M_AXIS(m_if), .M_AXIS_TSTRB(tstrb),
        .OVF_STICKY(ovf), .LAST_MISMATCH(mm), .BEAT_CNT(cnt));

    complex_iq_combiner_axis #(.DATA_W(32), .PIPE_STAGES(3), .SATURATE(0)) dut_w (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst), .MODE(mode), .STATUS_CLR(status_clr),
        .S0_AXIS(s0w), .S1_AXIS(s1w), .M_AXIS(mw), .M_AXIS_TSTRB(tstrb_w),
        .OVF_STICKY(ovf_w), .LAST_MISMATCH(mm_w), .BEAT_CNT(cnt_w));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                         input logic la, input logic lb, input logic va, input logic vb);
        s0_if.TDATA  = a;
        s1_if.TDATA  = b;
        mode         = m;
        s0_if.TLAST  = la;
        s1_if.TLAST  = lb;
        s0_if.TVALID = va;
        s1_if.TVALID = vb;
    endtask

    // Saturating fit of an exact integer into 32-bit signed.
    function automatic logic [31:0] fit32(input longint r, inout bit o);
        if (r > 64'sd2147483647) begin
            o = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (r < -64'sd2147483648) begin
            o = 1'b1;
            return 32'h8000_0000;
        end
        return r[31:0];
    endfunction

    // Expected {ovf, r_hi, r_lo} for one joined beat with saturation.
    function automatic logic [64:0] ref_beat(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] m);
        longint ah, al, bh, bl, rh, rl;
        bit     o;
        logic [31:0] h, l;
        ah = longint'($signed(a[63:32]));
        al = longint'($signed(a[31:0]));
        bh = longint'($signed(b[63:32]));
        bl = longint'($signed(b[31:0]));
        case (m)
            2'd0:    begin rh = ah + bl; rl = al - bh; end
            2'd1:    begin rh = ah + bh; rl = al + bl; end
            2'd2:    begin rh = ah - bh; rl = al - bl; end
            default: begin rh = ah - bl; rl = al + bh; end
        endcase
        o = 1'b0;
        h = fit32(rh, o);
        l = fit32(rl, o);
        return {o, h, l};
    endfunction

    task automatic stream(input int n, input bit toggle, input int mm_idx);
        logic [64:0] exp_q[$];
        logic        exp_l[$];
        logic [63:0] a, b, prev_d;
        logic [64:0] e;
        logic [1:0]  m;
        logic        l0, l1, va, vb, prev_l, stall;
        bit          exp_ovf, exp_mm;
        int          sent, got, budget;
        sent = 0; got = 0; budget = 0; exp_ovf = 0; exp_mm = 0;
        stall = 0; prev_d = '0; prev_l = 0; va = 0; vb = 0;
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; m = 2'($urandom_range(0, 3));
        l0 = ($urandom_range(0, 3) == 0); l1 = l0;
        if (mm_idx == 0) begin l0 = 1'b1; l1 = 1'b0; end
        while (got < n && budget < 4000) begin
            if (sent < n) begin
                if (!va) va = 1'($urandom_range(0, 1));
                if (!vb) vb = 1'($urandom_range(0, 1));
            end
            drive(a, b, m, l0, l1, va, vb);
            m_ready = toggle ? ~m_ready : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stall) begin
                chk("stall_data", m_if.TDATA, prev_d);
                chk("stall_last", m_if.TLAST, prev_l);
            end
            if (m_if.TVALID && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    exp_ovf |= e[64];
                    chk("stream_data", m_if.TDATA, e[63:0]);
                    chk("stream_last", m_if.TLAST, exp_l.pop_front());
                end
                got++;
            end
            stall  = m_if.TVALID && !m_ready;
            prev_d = m_if.TDATA;
            prev_l = m_if.TLAST;
            if (va && vb && s0_if.TREADY) begin
                exp_q.push_back(ref_beat(a, b, m));
                exp_l.push_back(l0 | l1);
                exp_mm |= (l0 != l1);
                sent++;
                beat_exp++;
                va = 0; vb = 0;
                a = {$urandom, $urandom}; b = {$urandom, $urandom}; m = 2'($urandom_range(0, 3));
                l0 = ($urandom_range(0, 3) == 0); l1 = l0;
                if (sent == mm_idx) begin l0 = 1'b1; l1 = 1'b0; end
            end
            step();
            budget++;
        end
        drive(64'h0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_ready = 1'b1;
        chk("stream_count", 64'(got), 64'(n));
        @(negedge clk);
        chk("stream_beatcnt", cnt, 64'(beat_exp));
        chk("stream_ovf", ovf, exp_ovf);
        chk("stream_mismatch", mm, exp_mm);
        step();
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        @(negedge clk);
        chk("clr_ovf", ovf, 1'b0);
        chk("clr_mismatch", mm, 1'b0);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0; beat_exp = 0;
        rst = 1'b1; status_clr = 1'b0; m_ready = 1'b0;
        drive(64'h1, 64'h2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s0_tready", s0_if.TREADY, 1'b0);
        chk("rst_s1_tready", s1_if.TREADY, 1'b0);
        chk("rst_tvalid", m_if.TVALID, 1'b0);
        chk("rst_tdata", m_if.TDATA, 64'h0);
        chk("rst_tlast", m_if.TLAST, 1'b0);
        chk("rst_beatcnt", cnt, 64'h0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_mismatch", mm, 1'b0);
        chk("tstrb", tstrb, 8'hFF);
        step();
        rst = 1'b0; m_ready = 1'b1;
        drive(64'h0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Cross mode single beat and latency on both pipe depths.
        drive({32'd5, 32'd7}, {32'd2, 32'd3}, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t1_s0_tready", s0_if.TREADY, 1'b1);
        step();
        drive(64'h0, 64'h0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_early_valid", m_if.TVALID, 1'b0);
        step();
        @(negedge clk);
        chk("t1_valid", m_if.TVALID, 1'b1);
        chk("t1_data", m_if.TDATA, {32'd8, 32'd5});
        chk("t1_w_early_valid", mw.TVALID, 1'b0);
        step();
        @(negedge clk);
        chk("t1_valid_once", m_if.TVALID, 1'b0);
        chk("t1_w_valid", mw.TVALID, 1'b1);
        chk("t1_w_data", mw.TDATA, {32'd8, 32'd5});
        chk("t1_beatcnt", cnt, 64'd1);
        chk("t1_ovf_clear", ovf, 1'b0);
        beat_exp = 1;
        step();

        // Positive and negative overflow, saturate vs wrap, mode change between beats.
        drive({32'h7FFF_FFFF, 32'h0}, {32'h1, 32'h0}, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        drive({32'h0, 32'h8000_0000}, {32'h0, 32'h1}, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        drive(64'h0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_sat_pos", m_if.TDATA, {32'h7FFF_FFFF, 32'h0});
        chk("t4_ovf_before_leave", ovf, 1'b0);
        step();
        @(negedge clk);
        chk("t4_sat_neg", m_if.TDATA, {32'h0, 32'h8000_0000});
        chk("t4_ovf", ovf, 1'b1);
        chk("t4_wrap_pos", mw.TDATA, {32'h8000_0000, 32'h0});
        chk("t4_w_ovf_before_leave", ovf_w, 1'b0);
        step();
        @(negedge clk);
        chk("t4_wrap_neg", mw.TDATA, {32'h0, 32'h7FFF_FFFF});
        chk("t4_w_ovf", ovf_w, 1'b1);
        chk("t4_beatcnt", cnt, 64'd3);
        beat_exp = 3;
        step();
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        @(negedge clk);
        chk("t4_ovf_cleared", ovf, 1'b0);
        step();

        // One-sided valid must not consume a beat.
        drive({32'd100, 32'd200}, {32'd1, 32'd2}, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_s0_tready_low", s0_if.TREADY, 1'b0);
            chk("t2_no_output", m_if.TVALID, 1'b0);
            step();
        end
        chk("t2_beatcnt_held", cnt, 64'(beat_exp));
        s1_if.TVALID = 1'b1;
        @(negedge clk);
        chk("t2_s0_tready", s0_if.TREADY, 1'b1);
        chk("t2_s1_tready", s1_if.TREADY, 1'b1);
        step();
        drive(64'h0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat_exp++;
        step();
        @(negedge clk);
        chk("t2_valid", m_if.TVALID, 1'b1);
        chk("t2_data", m_if.TDATA, {32'd101, 32'd202});
        step();
        @(negedge clk);
        chk("t2_single", m_if.TVALID, 1'b0);
        chk("t2_beatcnt", cnt, 64'(beat_exp));
        step();

        stream(16, 1'b1, -1);
        stream(8, 1'b0, 3);
        stream(40, 1'b0, -1);

        // Reset with two beats in flight discards them.
        m_ready = 1'b0;
        drive({32'd1, 32'd2}, {32'd3, 32'd4}, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        drive({32'd5, 32'd6}, {32'd7, 32'd8}, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        drive(64'h0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_inflight_valid", m_if.TVALID, 1'b1);
        chk("t6_mismatch_set", mm, 1'b1);
        chk("t6_beatcnt", cnt, 64'(beat_exp + 2));
        step();
        rst = 1'b1;
        step();
        m_ready = 1'b1;
        drive(64'h0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6_tvalid", m_if.TVALID, 1'b0);
        chk("t6_beatcnt_zero", cnt, 64'h0);
        chk("t6_mismatch_zero", mm, 1'b0);
        chk("t6_ovf_zero", ovf, 1'b0);
        chk("t6_tready_in_reset", s0_if.TREADY, 1'b0);
        step();
        rst = 1'b0;
        drive(64'h0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_output", m_if.TVALID, 1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
